tt_um_johannakin1_sum_uart_tx: RTL
==================================

Name: tt_um_johannakin1_sum_uart_tx

Overview:
- TinyTapeout top-level serial transmitter, the transmit-side companion of the team's parallel-sum tile.
- Serializes the byte on ui_in as an 8N1 UART frame on a single pin.
- Keeps a running 8-bit modulo-256 sum of every byte sent, shown on uo_out, so the receiver end can cross-check the stream.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..4095.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- ena  input  1  power-good; ignored
- ui_in  input  8  transmit data byte
- uo_out  output  8  running checksum (sum of sent bytes mod 256)
- uio_in  input  8  [0] send request; [1] clear; [7:2] unused
- uio_out  output  8  [4] tx; [5] busy; [6] done pulse; [7] overrun; [3:0] = 0
- uio_oe  output  8  constant 8'hF0

Behaviour:
- Reset (rst_n low at a clk edge):
  - tx=1, busy=0, done=0, overrun=0, uo_out=0.
  - FSM goes to IDLE; synchronizers are cleared.
  - A reset mid-frame aborts the frame; tx is high after that edge.
- Input synchronization:
  - uio_in[0] and uio_in[1] each pass through a 2-flop synchronizer.
  - Send uses rising-edge detect on the synchronized signal.
  - Clear is level-sensitive on the synchronized signal.
- Send latency:
  - uio_in[0] first sampled high at edge k; in IDLE, edge k+2 captures ui_in into the shift register.
  - On the same edge k+2: FSM enters START, tx=0, busy=1.
- FSM states: IDLE, START, DATA, STOP, plus PARITY only when the optional feature is compiled in.
  - Each non-IDLE state holds one bit for exactly CLKS_PER_BIT cycles, counted by a baud counter.
  - DATA sends 8 bits LSB first, using a 3-bit bit index.
  - STOP drives tx=1.
  - At the end of STOP: return to IDLE, busy=0, done=1 for one cycle, uo_out += sent byte (8-bit wrap, carry discarded).
- Frame length: 10*CLKS_PER_BIT cycles from tx falling to busy falling.
- Back-to-back: IDLE accepts a new send edge in the cycle right after done.
- Send edge while busy (including the last STOP cycle):
  - ignored; the frame is unaffected;
  - overrun=1 (sticky).
- Clear high: uo_out=0 and overrun=0 at the next edge. An in-flight frame continues.
- Clear and frame completion on the same edge: clear wins; uo_out=0, done still pulses.
- ui_in is sampled only at the capture edge; later changes have no effect.

Optional Feature:
- Macro: TT_SUMTX_PARITY_EN
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - It sends even parity (XOR of the 8 data bits).
  - Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state; frame is 8N1.

Decomposition:
- Package tt_sumtx_pkg:
  - FSM state enum;
  - DATA_BITS=8;
  - FRAME_BITS (10, or 11 with parity);
  - uio bit-index constants (SEND=0, CLR=1, TX=4, BUSY=5, DONE=6, OVR=7);
  - UIO_OE_VAL=8'hF0.
- One sub-module, tt_sumtx_sync_edge: 2-flop synchronizer with a registered previous value and a rise-pulse output. Instantiate it twice (send, clear); only the level output is used for clear.

Test Plan:
- CLKS_PER_BIT=4, ui_in=0xA5, pulse uio_in[0]:
  - tx bits (4 cycles each) = 0,1,0,1,0,0,1,0,1,1;
  - busy high for 40 cycles; one done pulse; uo_out=0xA5.
- Then ui_in=0x7F, send: uo_out=0x24 (wrap); overrun=0.
- Second send edge 12 cycles into a frame:
  - frame bits unchanged; no extra frame; overrun=1.
  - Then clear high for 3 cycles: uo_out=0, overrun=0.
- Clear asserted so its synchronized level lands on the frame-completion edge: done pulses, uo_out=0.
- rst_n low 20 cycles into a frame:
  - next edge tx=1, busy=0, uo_out=0;
  - a subsequent 0x3C send completes normally with uo_out=0x3C.
- With TT_SUMTX_PARITY_EN, ui_in=0xA5 (four ones): parity bit=0, frame 44 cycles. With ui_in=0x01: parity bit=1.

Source files
------------

// File: rtl/tt_sumtx_pkg.sv
// Shared types and constants for the summing UART transmitter tile.
// Optional build macro: TT_SUMTX_PARITY_EN (adds an even-parity bit per frame).
package tt_sumtx_pkg;

  localparam int DATA_BITS = 8;

`ifdef TT_SUMTX_PARITY_EN
  localparam int FRAME_BITS = 11;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
`else
  localparam int FRAME_BITS = 10;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_e;
`endif

  // uio bit positions
  localparam int UIO_SEND = 0;
  localparam int UIO_CLR  = 1;
  localparam int UIO_TX   = 4;
  localparam int UIO_BUSY = 5;
  localparam int UIO_DONE = 6;
  localparam int UIO_OVR  = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

  // Status bits presented on the bidirectional pins.
  typedef struct packed {
    logic ovr;
    logic done;
    logic busy;
    logic tx;
  } tx_status_t;

  // Place status bits at their uio positions; unused low nibble stays 0.
  function automatic logic [7:0] pack_uio(tx_status_t s);
    logic [7:0] v;
    v           = '0;
    v[UIO_TX]   = s.tx;
    v[UIO_BUSY] = s.busy;
    v[UIO_DONE] = s.done;
    v[UIO_OVR]  = s.ovr;
    return v;
  endfunction

endpackage

// File: rtl/tt_sumtx_sync_edge.sv
// Two-flop synchronizer plus a registered previous value for rise detection.
module tt_sumtx_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  // [0],[1]: metastability chain, [2]: previous synchronized value
  logic [2:0] sync_pipe;

  // Shift the raw input through the chain; synchronous clear on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[1:0], d};
  end

  assign level = sync_pipe[1];
  assign rise  = sync_pipe[1] & ~sync_pipe[2];

endmodule

// File: rtl/tt_um_johannakin1_sum_uart_tx.sv
// TinyTapeout UART transmitter with a running modulo-256 sum of sent bytes.
// Optional build macro: TT_SUMTX_PARITY_EN (8E1 frames instead of 8N1).
module tt_um_johannakin1_sum_uart_tx
  import tt_sumtx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [11:0] BAUD_LAST = 12'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e  state_q, state_d;
  logic [11:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  data_q;
  logic [7:0]  sum_q;
  logic        done_q;
  logic        ovr_q;
  logic        capture, finish, bit_end, busy, tx;
  logic [1:0]  sync_lvl, sync_rise;
  logic        send_rise, clr_lvl;
  tx_status_t  status;

  // Lane 0 = send request, lane 1 = clear.
  tt_sumtx_sync_edge u_sync [1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uio_in[UIO_CLR:UIO_SEND]),
    .level (sync_lvl),
    .rise  (sync_rise)
  );

  assign send_rise = sync_rise[UIO_SEND];
  assign clr_lvl   = sync_lvl[UIO_CLR];
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign busy      = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, capture/finish strobes and the serial line level.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    finish  = 1'b0;
    tx      = 1'b1;
    case (state_q)
      IDLE: begin
        if (send_rise) begin
          state_d = START;
          capture = 1'b1;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx = data_q[bit_idx];
        if (bit_end && (bit_idx == BIT_LAST)) begin
`ifdef TT_SUMTX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef TT_SUMTX_PARITY_EN
      PARITY: begin
        tx = ^data_q;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        tx = 1'b1;
        if (bit_end) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Baud counter: runs only while a frame is in flight, wraps every bit.
  always_ff @(posedge clk) begin
    if (!rst_n)                           baud_cnt <= '0;
    else if ((state_q == IDLE) || bit_end) baud_cnt <= '0;
    else                                  baud_cnt <= baud_cnt + 12'd1;
  end

  // Data byte capture and bit index, LSB first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      bit_idx <= '0;
    end else if (capture) begin
      data_q  <= ui_in;
      bit_idx <= '0;
    end else if ((state_q == DATA) && bit_end) begin
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // Checksum, done pulse and sticky overrun; clear beats completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      done_q <= finish;
      if (clr_lvl)     sum_q <= '0;
      else if (finish) sum_q <= sum_q + data_q;
      if (clr_lvl)                ovr_q <= 1'b0;
      else if (send_rise && busy) ovr_q <= 1'b1;
    end
  end

  assign status  = '{ovr: ovr_q, done: done_q, busy: busy, tx: tx};
  assign uo_out  = sum_q;
  assign uio_out = pack_uio(status);
  assign uio_oe  = UIO_OE_VAL;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:2], sync_rise[UIO_CLR], sync_lvl[UIO_SEND]};

endmodule
